// File: rtl/loopbuffer_pkg.sv
// rtl/loopbuffer_pkg.sv - shared defaults, state encoding and PC step for the loop-buffer fetch path
package loopbuffer_pkg;

  localparam int unsigned LB_DEPTH   = 16;
  localparam int unsigned LB_MAX_OUT = 4;
  localparam logic [31:0] PC_INC     = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/loopbuffer_credit_counter.sv
// rtl/loopbuffer_credit_counter.sv - buffer occupancy / outstanding request pair with credit check
module loopbuffer_credit_counter
  import loopbuffer_pkg::*;
#(
  parameter int unsigned DEPTH   = LB_DEPTH,
  parameter int unsigned MAX_OUT = LB_MAX_OUT,
  parameter int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_outst_i,
  input  logic          dec_outst_i,
  input  logic          inc_occ_i,
  input  logic          dec_occ_i,
  input  logic          clr_occ_i,
  output logic [CW-1:0] occ_o,
  output logic [CW-1:0] outst_o,
  output logic [CW-1:0] outst_next_o,
  output logic          credit_ok_o
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW:0]   sum;

  always_comb begin
    outst_d = outst_q;
    if (inc_outst_i && !dec_outst_i && outst_q < MAX_OUT_C) begin
      outst_d = outst_q + CW'(1);
    end else if (!inc_outst_i && dec_outst_i && outst_q != '0) begin
      outst_d = outst_q - CW'(1);
    end

    // Counters saturate rather than wrap; a clear wins over a simultaneous write.
    occ_d = occ_q;
    if (clr_occ_i) begin
      occ_d = '0;
    end else if (inc_occ_i && !dec_occ_i && occ_q < DEPTH_C) begin
      occ_d = occ_q + CW'(1);
    end else if (!inc_occ_i && dec_occ_i && occ_q != '0) begin
      occ_d = occ_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q   <= '0;
      outst_q <= '0;
    end else begin
      occ_q   <= occ_d;
      outst_q <= outst_d;
    end
  end

  assign sum          = {1'b0, occ_q} + {1'b0, outst_q};
  assign credit_ok_o  = (sum < {1'b0, DEPTH_C}) && (outst_q < MAX_OUT_C);
  assign occ_o        = occ_q;
  assign outst_o      = outst_q;
  assign outst_next_o = outst_d;

endmodule

// File: rtl/loopbuffer_fetch_ctrl.sv
// rtl/loopbuffer_fetch_ctrl.sv - credit-gated sequential fetch scheduler with redirect drain
module loopbuffer_fetch_ctrl
  import loopbuffer_pkg::*;
#(
  parameter int unsigned DEPTH    = LB_DEPTH,
  parameter int unsigned MAX_OUT  = LB_MAX_OUT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iFLUSH_REQ,
  input  logic [31:0] iFLUSH_PC,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  input  logic        iFETCH_ACK,
  input  logic        iFETCH_VALID,
  output logic        oBUF_WR_EN,
  input  logic        iBUF_RD,
  output logic        oBUF_FLUSH,
  output logic        oBUSY_FLUSH
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic          busy_q;
  logic [CW-1:0] occ, outst, outst_next;
  logic          credit_ok;
  logic          accept;

  assign oFETCH_REQ  = (state_q == ST_RUN) && credit_ok && !iFLUSH_REQ;
  assign accept      = oFETCH_REQ && iFETCH_ACK;
  assign oBUF_WR_EN  = (state_q == ST_RUN) && iFETCH_VALID && !iFLUSH_REQ;
  assign oBUF_FLUSH  = iFLUSH_REQ;
  assign oFETCH_ADDR = pc_q;
  assign oBUSY_FLUSH = busy_q;

  loopbuffer_credit_counter #(
    .DEPTH  (DEPTH),
    .MAX_OUT(MAX_OUT),
    .CW     (CW)
  ) u_credit (
    .clk_i       (iCLOCK),
    .rst_i       (iRESET),
    .inc_outst_i (accept),
    .dec_outst_i (iFETCH_VALID),
    .inc_occ_i   (oBUF_WR_EN),
    .dec_occ_i   (iBUF_RD),
    .clr_occ_i   (iFLUSH_REQ),
    .occ_o       (occ),
    .outst_o     (outst),
    .outst_next_o(outst_next),
    .credit_ok_o (credit_ok)
  );

  // Returns still owed by memory after a redirect must be swallowed before fetch resumes.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
    end else if (iFLUSH_REQ) begin
      pc_q <= iFLUSH_PC & ~32'h3;
      if (outst_next != '0) begin
        state_q <= ST_DRAIN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= ST_RUN;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) pc_q <= pc_q + PC_INC;
        end
        ST_DRAIN: begin
          if (outst_next == '0) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  a_rd_empty: assert property (@(posedge iCLOCK) disable iff (iRESET) !(iBUF_RD && occ == '0))
    else $error("buffer read while empty");
  a_ret_none: assert property (@(posedge iCLOCK) disable iff (iRESET) !(iFETCH_VALID && outst == '0))
    else $error("fetch return with nothing outstanding");

endmodule

// File: tb/tb_loopbuffer_fetch_ctrl.sv
// tb/tb_loopbuffer_fetch_ctrl.sv - scoreboard bench for the loop-buffer fetch scheduler
module tb_loopbuffer_fetch_ctrl;

  localparam int          DEPTH    = 16;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        iCLOCK = 1'b0;
  logic        iRESET;
  logic        iFLUSH_REQ;
  logic [31:0] iFLUSH_PC;
  logic        oFETCH_REQ;
  logic [31:0] oFETCH_ADDR;
  logic        iFETCH_ACK;
  logic        iFETCH_VALID;
  logic        oBUF_WR_EN;
  logic        iBUF_RD;
  logic        oBUF_FLUSH;
  logic        oBUSY_FLUSH;

  loopbuffer_fetch_ctrl #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT),
    .RESET_PC(RESET_PC)
  ) dut (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iFLUSH_REQ  (iFLUSH_REQ),
    .iFLUSH_PC   (iFLUSH_PC),
    .oFETCH_REQ  (oFETCH_REQ),
    .oFETCH_ADDR (oFETCH_ADDR),
    .iFETCH_ACK  (iFETCH_ACK),
    .iFETCH_VALID(iFETCH_VALID),
    .oBUF_WR_EN  (oBUF_WR_EN),
    .iBUF_RD     (iBUF_RD),
    .oBUF_FLUSH  (oBUF_FLUSH),
    .oBUSY_FLUSH (oBUSY_FLUSH)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic req;
    logic wr;
    logic fl;
    logic busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int          m_occ;
  int          m_outst;
  logic [31:0] m_pc;
  bit          m_drain;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_occ   = 0;
    m_outst = 0;
    m_pc    = RESET_PC;
    m_drain = 0;
  endtask

  task automatic cycle(input logic fl, input logic [31:0] fpc, input logic ack,
                       input logic vld_raw, input logic rd_raw);
    logic vld, rd, req, wr;
    int   new_outst;
    @(negedge iCLOCK);
    vld = vld_raw && (m_outst > 0);
    rd  = rd_raw && (m_occ > 0);
    iFLUSH_REQ   = fl;
    iFLUSH_PC    = fpc;
    iFETCH_ACK   = ack;
    iFETCH_VALID = vld;
    iBUF_RD      = rd;

    req = !m_drain && !fl && (m_occ + m_outst < DEPTH) && (m_outst < MAX_OUT);
    wr  = vld && !m_drain && !fl;
    exp_q.push_back('{req: req, wr: wr, fl: fl, busy: m_drain});
    if (req && ack) addr_q.push_back(m_pc);

    new_outst = m_outst + ((req && ack) ? 1 : 0) - (vld ? 1 : 0);
    if (fl)            m_occ = 0;
    else               m_occ = m_occ + (wr ? 1 : 0) - (rd ? 1 : 0);
    if (fl)            m_pc = {fpc[31:2], 2'b00};
    else if (req && ack) m_pc = m_pc + 32'd4;
    m_drain = (fl || m_drain) && (new_outst != 0);
    m_outst = new_outst;
  endtask

  always @(negedge iCLOCK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fetch_req", {31'd0, oFETCH_REQ}, {31'd0, e.req});
      chk("buf_wr_en", {31'd0, oBUF_WR_EN}, {31'd0, e.wr});
      chk("buf_flush", {31'd0, oBUF_FLUSH}, {31'd0, e.fl});
      chk("busy_flush", {31'd0, oBUSY_FLUSH}, {31'd0, e.busy});
      if (oFETCH_REQ && iFETCH_ACK) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_addr: unexpected handshake at 0x%08h, none required, at %0t",
                   oFETCH_ADDR, $time);
        end else begin
          chk("fetch_addr", oFETCH_ADDR, addr_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, {31'd0, oFETCH_REQ}, 32'd1);
    chk({tag, "_addr"}, oFETCH_ADDR, RESET_PC);
    chk({tag, "_wr"}, {31'd0, oBUF_WR_EN}, 32'd0);
    chk({tag, "_flush"}, {31'd0, oBUF_FLUSH}, 32'd0);
    chk({tag, "_busy"}, {31'd0, oBUSY_FLUSH}, 32'd0);
  endtask

  initial begin
    int pf, pa, pv, pr;
    logic [31:0] fpc;
    iRESET       = 1'b1;
    iFLUSH_REQ   = 1'b0;
    iFLUSH_PC    = 32'd0;
    iFETCH_ACK   = 1'b0;
    iFETCH_VALID = 1'b0;
    iBUF_RD      = 1'b0;
    m_reset();
    #1;
    check_reset_vals("reset");
    #11;
    iRESET = 1'b0;

    repeat (6)  cycle(0, 0, 1, 0, 0);
    repeat (4)  cycle(0, 0, 0, 1, 0);
    repeat (40) cycle(0, 0, 1, 1, 0);
    repeat (3)  cycle(0, 0, 0, 0, 1);
    repeat (3)  cycle(0, 0, 1, 0, 0);
    cycle(1, 32'h0000_1003, 1, 0, 0);
    repeat (3)  cycle(0, 0, 1, 1, 0);
    repeat (2)  cycle(0, 0, 1, 0, 0);
    repeat (2)  cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h0000_4000, 0, 0, 0);
    repeat (2)  cycle(0, 0, 1, 0, 0);
    cycle(1, 32'h0000_3000, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h0000_2000, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (2)  cycle(0, 0, 1, 0, 0);
    repeat (2)  cycle(0, 0, 0, 1, 0);
    cycle(1, 32'hFFFF_FFFE, 0, 0, 0);
    repeat (2)  cycle(0, 0, 1, 0, 0);
    repeat (2)  cycle(0, 0, 0, 1, 0);
    repeat (14) cycle(0, 0, 1, 1, 1);

    repeat (2)  cycle(0, 0, 1, 0, 0);
    cycle(1, 32'h0000_5000, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(negedge iCLOCK);
    iFLUSH_REQ   = 1'b0;
    iFETCH_ACK   = 1'b0;
    iFETCH_VALID = 1'b0;
    iBUF_RD      = 1'b0;
    #2;
    chk("pre_reset_busy", {31'd0, oBUSY_FLUSH}, 32'd1);
    iRESET = 1'b1;
    #1;
    check_reset_vals("mid_drain_reset");
    @(posedge iCLOCK);
    #2;
    iRESET = 1'b0;
    m_reset();

    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin pf = 2;  pa = 80; pv = 60; pr = 30; end
        1: begin pf = 5;  pa = 50; pv = 50; pr = 70; end
        2: begin pf = 10; pa = 90; pv = 30; pr = 10; end
        default: begin pf = 1; pa = 70; pv = 80; pr = 50; end
      endcase
      for (int i = 0; i < 600; i++) begin
        fpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
        cycle($urandom_range(0, 99) < pf, fpc, $urandom_range(0, 99) < pa,
              $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
      end
    end

    repeat (2) cycle(0, 0, 0, 0, 0);
    @(negedge iCLOCK);
    #3;
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("addr_q_drained", addr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
